// File: rtl/hscale_coff_gen_pkg.sv
// Shared definitions for the horizontal scaler front end.
// Holds the legal step range (unsigned 8.8), the full-scale weight,
// the line-tracking state encoding and the step clamp helper.
package hscale_coff_gen_pkg;

  localparam logic [15:0] STEP_ONE  = 16'h0100;  // 1.0 in 8.8
  localparam logic [15:0] STEP_MAX  = 16'h0400;  // 4.0 in 8.8
  localparam logic [7:0]  COFF_FULL = 8'd255;

  typedef enum logic [1:0] {
    WAIT_BLANK = 2'd0,
    IDLE       = 2'd1,
    RUN        = 2'd2
  } state_e;

  // Force the step into [STEP_ONE, STEP_MAX]. A step below 1.0 would need
  // more than one output per input pixel, which this block cannot produce.
  function automatic logic [15:0] clamp_step(input logic [15:0] s);
    if (s < STEP_ONE) return STEP_ONE;
    if (s > STEP_MAX) return STEP_MAX;
    return s;
  endfunction

  function automatic logic step_out_of_range(input logic [15:0] s);
    return (s < STEP_ONE) || (s > STEP_MAX);
  endfunction

endpackage

// File: rtl/hscale_phase_acc.sv
// Phase accumulator for the horizontal scaler.
// Holds the output-pixel source position pos (integer.frac, 8 frac bits)
// and the step latched at line start.
//   sys_clk, sys_rst : clock, async active-high reset
//   load_i           : line start; clears pos and latches step_i
//   step_i           : clamped step (8.8)
//   en_i             : a valid, non-saturated pixel with index n_i is present
//   n_i              : index of the current source pixel
//   advance_o        : an output pixel lands between pixels n_i-1 and n_i
//   frac_o           : fractional part of pos (weight of the right pixel)
module hscale_phase_acc
  import hscale_coff_gen_pkg::*;
#(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 load_i,
  input  logic [15:0]          step_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] n_i,
  output logic                 advance_o,
  output logic [7:0]           frac_o
);

  logic [CNT_WIDTH+7:0] pos_q, pos_d;
  logic [15:0]          step_q, step_d;
  logic [CNT_WIDTH:0]   target;

  // One extra bit so pos_int + 1 cannot wrap onto a small index.
  assign target    = {1'b0, pos_q[CNT_WIDTH+7:8]} + (CNT_WIDTH+1)'(1);
  assign advance_o = en_i && ({1'b0, n_i} == target);
  assign frac_o    = pos_q[7:0];

  always_comb begin
    pos_d  = pos_q;
    step_d = step_q;
    if (load_i) begin
      pos_d  = '0;
      step_d = step_i;
    end else if (advance_o) begin
      pos_d = pos_q + (CNT_WIDTH+8)'(step_q);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pos_q  <= '0;
      step_q <= '0;
    end else begin
      pos_q  <= pos_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/hscale_coff_gen.sv
// Horizontal bilinear scale-down front end. Pairs each pixel with its
// predecessor, attaches the horizontal weights for that pair and flags the
// pairs that produce an output pixel. Vertical weights are latched per line
// and forwarded. All outputs are registered one cycle after the input edge.
//   sys_clk, sys_rst          : clock, async active-high reset
//   scale_step                : src/dst ratio, 8.8, latched at line start
//   v_a_coff, v_b_coff        : vertical weights, latched at line start
//   pix_in, data_en_in        : pixel stream, data_en_in high for one line
//   a, b, a_coff, b_coff      : pair and horizontal weights
//   a_coff_next, b_coff_next  : latched vertical weights
//   data_en_out, scale_en_out : line-valid and output-pixel strobes
//   line_out_cnt              : output pixels in the last completed line
//   step_err                  : the latched step was clamped
module hscale_coff_gen
  import hscale_coff_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [15:0]           scale_step,
  input  logic [7:0]            v_a_coff,
  input  logic [7:0]            v_b_coff,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  data_en_in,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [7:0]            a_coff,
  output logic [7:0]            b_coff,
  output logic [7:0]            a_coff_next,
  output logic [7:0]            b_coff_next,
  output logic                  data_en_out,
  output logic                  scale_en_out,
  output logic [CNT_WIDTH-1:0]  line_out_cnt,
  output logic                  step_err
);

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] prev_q, a_q, b_q;
  logic [7:0]            a_coff_q, b_coff_q, a_next_q, b_next_q;
  logic                  de_q, sen_q, err_q;
  logic [CNT_WIDTH-1:0]  n_q, out_cnt_q, line_cnt_q;

  logic line_start, run_pix, line_end, n_sat, advance;
  logic [7:0] frac;

  assign line_start = (state_q == IDLE) && data_en_in;
  assign run_pix    = (state_q == RUN) && data_en_in;
  assign line_end   = (state_q == RUN) && !data_en_in;
  // Once n hits all-ones it stays there and no more outputs are produced.
  assign n_sat      = &n_q;

  hscale_phase_acc #(.CNT_WIDTH(CNT_WIDTH)) u_acc (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .load_i    (line_start),
    .step_i    (clamp_step(scale_step)),
    .en_i      (run_pix && !n_sat),
    .n_i       (n_q),
    .advance_o (advance),
    .frac_o    (frac)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_BLANK: if (!data_en_in) state_d = IDLE;
      IDLE:       if (data_en_in)  state_d = RUN;
      RUN:        if (!data_en_in) state_d = IDLE;
      default:                     state_d = WAIT_BLANK;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= WAIT_BLANK;
    else         state_q <= state_d;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      prev_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_coff_q   <= '0;
      b_coff_q   <= '0;
      a_next_q   <= '0;
      b_next_q   <= '0;
      de_q       <= 1'b0;
      sen_q      <= 1'b0;
      err_q      <= 1'b0;
      n_q        <= '0;
      out_cnt_q  <= '0;
      line_cnt_q <= '0;
    end else begin
      de_q  <= line_start || run_pix;
      sen_q <= advance;
      if (line_start) begin
        err_q     <= step_out_of_range(scale_step);
        a_next_q  <= v_a_coff;
        b_next_q  <= v_b_coff;
        out_cnt_q <= '0;
        n_q       <= CNT_WIDTH'(1);  // the first pixel is n = 0
        prev_q    <= pix_in;
      end
      if (run_pix) begin
        a_q      <= prev_q;
        b_q      <= pix_in;
        prev_q   <= pix_in;
        b_coff_q <= frac;
        a_coff_q <= COFF_FULL - frac;
        if (!n_sat)  n_q       <= n_q + CNT_WIDTH'(1);
        if (advance) out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
      end
      if (line_end) line_cnt_q <= out_cnt_q;
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign a_coff       = a_coff_q;
  assign b_coff       = b_coff_q;
  assign a_coff_next  = a_next_q;
  assign b_coff_next  = b_next_q;
  assign data_en_out  = de_q;
  assign scale_en_out = sen_q;
  assign line_out_cnt = line_cnt_q;
  assign step_err     = err_q;

endmodule

// File: tb/tb_hscale_coff_gen.sv
module tb_hscale_coff_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [15:0] scale_step = 16'h0100;
  logic [7:0]  v_a_coff = '0, v_b_coff = '0;
  logic [7:0]  pix_in = '0;
  logic        data_en_in = 1'b0;
  logic [7:0]  a, b, a_coff, b_coff, a_coff_next, b_coff_next;
  logic        data_en_out, scale_en_out, step_err;
  logic [11:0] line_out_cnt;

  hscale_coff_gen #(.DATA_WIDTH(8), .CNT_WIDTH(12)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .scale_step(scale_step),
    .v_a_coff(v_a_coff), .v_b_coff(v_b_coff), .pix_in(pix_in),
    .data_en_in(data_en_in), .a(a), .b(b), .a_coff(a_coff), .b_coff(b_coff),
    .a_coff_next(a_coff_next), .b_coff_next(b_coff_next),
    .data_en_out(data_en_out), .scale_en_out(scale_en_out),
    .line_out_cnt(line_out_cnt), .step_err(step_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int a, b, ac, bc, an, bn, err;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   de_cnt = 0;
  logic [7:0] line_pix [0:4199];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts line-valid cycles and checks every output pixel
  // against the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (data_en_out) de_cnt++;
    if (scale_en_out) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pulse: got a=%0d b=%0d expected none at %0t", a, b, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("pair_a", a, e.a);
        check("pair_b", b, e.b);
        check("a_coff", a_coff, e.ac);
        check("b_coff", b_coff, e.bc);
        check("a_coff_next", a_coff_next, e.an);
        check("b_coff_next", b_coff_next, e.bn);
        check("step_err_pulse", step_err, e.err);
      end
    end
  end

  // Reference: output pixel k sits at source x = k*step/256. It is the
  // blend of pixels floor(x) and floor(x)+1 with right weight frac(x),
  // and exists only if that right pixel lies in the line and below the
  // saturated index 4095.
  task automatic push_expected(input int len, input int step_raw, input int va,
                               input int vb, output int cnt, output int err);
    int s, x, i, f;
    s   = (step_raw < 256) ? 256 : ((step_raw > 1024) ? 1024 : step_raw);
    err = (step_raw < 256 || step_raw > 1024) ? 1 : 0;
    cnt = 0;
    for (int k = 0; k < 100000; k++) begin
      exp_t e;
      x = k * s; i = x / 256; f = x % 256;
      if (i + 1 > len - 1 || i + 1 > 4094) break;
      e.a = line_pix[i]; e.b = line_pix[i+1]; e.ac = 255 - f; e.bc = f;
      e.an = va; e.bn = vb; e.err = err;
      sbq.push_back(e);
      cnt++;
    end
  endtask

  // Drives one line. mid_idx >= 0 changes step and vertical weights at
  // that pixel; rst_at >= 0 pulses reset right after pixel rst_at is clocked.
  task automatic drive_line(input int len, input int step, input int va, input int vb,
                            input int mid_idx, input int new_step, input int rst_at);
    int cnt, err, de0, seen;
    push_expected((rst_at >= 0) ? rst_at : len, step, va, vb, cnt, err);
    de0 = de_cnt;
    for (int i = 0; i < len; i++) begin
      @(negedge sys_clk);
      data_en_in = 1'b1;
      pix_in     = line_pix[i];
      if (i == 0) begin
        scale_step = 16'(step); v_a_coff = 8'(va); v_b_coff = 8'(vb);
      end
      if (i == mid_idx) begin
        scale_step = 16'(new_step); v_a_coff = ~8'(va); v_b_coff = ~8'(vb);
      end
      if (i == rst_at) begin
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        check("rst_mid_de", data_en_out, 0);
        check("rst_mid_sen", scale_en_out, 0);
        check("rst_mid_pair", {a, b, a_coff, b_coff}, 0);
        check("rst_mid_misc", {a_coff_next, b_coff_next, line_out_cnt, step_err}, 0);
        #1 sys_rst = 1'b0;
      end
    end
    @(negedge sys_clk);
    data_en_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    seen = de_cnt - de0;
    check("line_out_cnt", line_out_cnt, (rst_at >= 0) ? 0 : cnt);
    check("de_cycles", seen, (rst_at >= 0) ? rst_at : len);
    check("step_err_line", step_err, (rst_at >= 0) ? 0 : err);
    check("sb_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #1 sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_de", data_en_out, 0);
    check("rst_sen", scale_en_out, 0);
    check("rst_pair", {a, b, a_coff, b_coff}, 0);
    check("rst_misc", {a_coff_next, b_coff_next, line_out_cnt, step_err}, 0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    for (int i = 0; i < 4; i++) line_pix[i] = 8'(10 * (i + 1));
    drive_line(4, 'h100, 11, 22, -1, 0, -1);
    for (int i = 0; i < 6; i++) line_pix[i] = 8'(16 * i);
    drive_line(6, 'h180, 33, 44, -1, 0, -1);
    for (int i = 0; i < 8; i++) line_pix[i] = 8'(i);
    drive_line(8, 'h200, 55, 66, -1, 0, -1);

    for (int i = 0; i < 12; i++) line_pix[i] = 8'($urandom);
    drive_line(12, 'h080, 1, 2, -1, 0, -1);
    drive_line(12, 'h300, 3, 4, -1, 0, -1);

    drive_line(10, 'h100, 70, 80, 3, 'h200, -1);
    drive_line(10, 'h200, 90, 100, -1, 0, -1);

    for (int i = 0; i < 10; i++) line_pix[i] = 8'($urandom);
    drive_line(10, 'h100, 5, 6, -1, 0, 5);
    drive_line(10, 'h100, 7, 8, -1, 0, -1);

    drive_line(1, 'h100, 9, 10, -1, 0, -1);

    for (int t = 0; t < 20; t++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) line_pix[i] = 8'($urandom);
      drive_line(len, $urandom_range('h0080, 'h0500), $urandom_range(0, 255),
                 $urandom_range(0, 255), -1, 0, -1);
    end

    for (int i = 0; i < 4100; i++) line_pix[i] = 8'($urandom);
    drive_line(4100, 'h100, 12, 34, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
